// File: rtl/pipeline_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer and registered in_ready.
// Stall holds contents, flush inserts a zero-control bubble, and saturating counters track stalls and flushes.
module pipeline_stage_skid #(
    parameter int CTRL_WIDTH  = 16,
    parameter int DATA_WIDTH  = 128,
    parameter bit CLEAR_DATA  = 1'b0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   cnt_clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_WIDTH-1:0]  in_ctrl,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_WIDTH-1:0]  out_ctrl,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [1:0]             occupancy,
    output logic [COUNT_WIDTH-1:0] stall_cnt,
    output logic [COUNT_WIDTH-1:0] flush_cnt
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is decoded from the registered state only, so it never depends on out_ready.
    // The state encoding equals the entry count, so occupancy exposes the FSM state directly.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CTRL_WIDTH-1:0]  main_ctrl_q, main_ctrl_d;
    logic [DATA_WIDTH-1:0]  main_data_q, main_data_d;
    logic [CTRL_WIDTH-1:0]  skid_ctrl_q, skid_ctrl_d;
    logic [DATA_WIDTH-1:0]  skid_data_q, skid_data_d;
    logic [COUNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [COUNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic in_fire;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid_in;
    logic stall_hit;
    logic flush_hit;

    assign in_fire   = in_valid & (state_q != ST_FULL);
    assign out_fire  = (state_q != ST_EMPTY) & out_ready;
    assign stall_hit = (state_q != ST_EMPTY) & ~out_ready;
    assign flush_hit = flush & (state_q != ST_EMPTY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d      = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_d      = ST_FULL;
                        load_skid_in = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d        = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q != ST_FULL);
        out_valid = (state_q != ST_EMPTY);
        occupancy = state_q;
        out_ctrl  = out_valid ? main_ctrl_q : '0;
        out_data  = main_data_q;
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

    // Flush clears control so stale entries can never look like live instructions.
    always_comb begin
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (CLEAR_DATA) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            if (load_main_in) begin
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else if (load_main_skid) begin
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
            end
            if (load_skid_in) begin
                skid_ctrl_d = in_ctrl;
                skid_data_d = in_data;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_hit && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush_hit && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: doc/pipeline_stage_skid.md
Name: pipeline_stage_skid

Overview:
- Generic, parametrised pipeline stage register for the RISC-V core.
- Successor to the fixed-field decode/execute register. Carries an opaque control field and data field, separately sized.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and no combinational ready path runs between stages.
- Stall holds contents instead of inserting a bubble. Flush inserts a bubble. Saturating stall/flush counters support performance debug.

Parameters:
- CTRL_WIDTH, 16: control bits per entry (RegWrite, MemWrite, Jump, Branch, ...). Forced to 0 on bubble/flush.
- DATA_WIDTH, 128: data bits per entry (operands, PC, imm, register indices).
- CLEAR_DATA, 0: 1 = data bits are zeroed on flush/reset; 0 = data bits hold their previous value.
- COUNT_WIDTH, 16: width of each performance counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all held entries this cycle
- cnt_clr  in  1  synchronous clear of both counters
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept (registered)
- in_ctrl  in  CTRL_WIDTH  upstream control field
- in_data  in  DATA_WIDTH  upstream data field
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_WIDTH  main control field, masked to 0 when out_valid=0
- out_data  out  DATA_WIDTH  main data field
- occupancy  out  2  entries held (0..2)
- stall_cnt  out  COUNT_WIDTH  cycles with out_valid=1 and out_ready=0
- flush_cnt  out  COUNT_WIDTH  flush cycles that discarded at least one valid entry

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: a main register (drives the out_* ports) and a skid register.
- Reset (rst=1, asynchronous): state EMPTY, out_valid=0, in_ready=1, occupancy=0, both ctrl registers 0, both data registers 0 (regardless of CLEAR_DATA), both counters 0.
- State machine: EMPTY (occupancy 0), ONE (occupancy 1), FULL (occupancy 2). in_ready=1 in EMPTY/ONE and 0 in FULL; it is a decoded registered state, not a function of out_ready.
- EMPTY:
  - in_fire -> ONE, main<=in.
  - Otherwise stay in EMPTY.
- ONE:
  - in_fire & out_fire -> ONE, main<=in.
  - in_fire only -> FULL, skid<=in.
  - out_fire only -> EMPTY.
  - Neither -> hold.
- FULL:
  - out_fire -> ONE, main<=skid.
  - Otherwise hold; this is the stall case, and contents are unchanged.
- Latency: 1 cycle from in_fire (in EMPTY) to out_valid. Sustained throughput is 1 entry/cycle while out_ready=1. Ordering is strictly FIFO.
- Flush (priority below rst, above all handshakes):
  - Next state EMPTY; any in_fire in that cycle is dropped.
  - Main and skid ctrl registers are cleared to 0.
  - Data registers are zeroed if CLEAR_DATA=1, otherwise held.
  - out_fire in the flush cycle still counts as accepted downstream; the flush affects only the next state.
- Flush and stall together: flush wins, and the stage becomes EMPTY.
- out_ctrl is forced to 0 combinationally whenever out_valid=0, so downstream sees a zero-control bubble.
- stall_cnt: +1 on each cycle with out_valid & !out_ready. Saturates at all-ones.
- flush_cnt: +1 on each flush cycle with occupancy!=0. Saturates at all-ones.
- cnt_clr: clears both counters to 0 and has priority over increment. It does not affect the datapath.
- Reset mid-operation: all entries are lost immediately (asynchronous), and outputs take their reset values before the next edge.
- No X propagation: every register is reset.

Test Plan:
- Stream: out_ready=1, in_valid=1 for 8 cycles with data 1..8 -> out_data 1..8 on consecutive cycles, first at cycle+1; occupancy stays 1; in_ready stays 1.
- Backpressure: load A=0x11, then drop out_ready while sending B=0x22 -> FULL, occupancy=2, in_ready=0 next cycle. C=0x33 is held upstream. Raise out_ready -> outputs A, B, C in order with no loss or duplication.
- Stall count: out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt=5, out_data and out_ctrl constant throughout.
- Flush in FULL with CLEAR_DATA=0 and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, out_data unchanged, flush_cnt=1, new input dropped. Flush in EMPTY -> flush_cnt unchanged.
- Saturation: COUNT_WIDTH=4, stall 20 cycles -> stall_cnt=15. Assert cnt_clr together with a stall -> stall_cnt=0 next cycle.
- Async reset: assert rst mid-cycle while FULL -> out_valid=0, in_ready=1, occupancy=0, counters 0 before the next clk edge. After deassert, a new entry passes with 1-cycle latency.
